// File: rtl/mm_sched_pkg.sv
// mm_sched_pkg: shared FSM states, parameter defaults and result saturation for the matrix-multiply job scheduler
package mm_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT} state_t;
  localparam int MAT_SIZE_DEF = 9;
  localparam int FRAC_SHIFT_DEF = 10;
  localparam int TIMEOUT_DEF = 255;
  function automatic logic signed [127:0] sat(input logic signed [127:0] v, input int dw);
    logic signed [127:0] mx;
    mx = (128'sd1 <<< (dw - 1)) - 128'sd1;
    return v > mx ? mx : v < -mx - 128'sd1 ? -mx - 128'sd1 : v;
  endfunction
endpackage

// File: rtl/mm_job_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter (req, last-served lp, en -> one-hot gnt; a tie goes to the requester that is not lp)
module rr_arb2
  import mm_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lp,
  input  logic       en,
  output logic [1:0] gnt
);
  always_comb gnt = !en ? 2'b00 : req == 2'b11 ? (lp ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mm_job_scheduler.sv
// mm_job_scheduler: shares one 3x3 multiplier between two requesters (req/gnt/op_* in, mm_* to multiplier, scaled res_* and job_done/job_err out)
module mm_job_scheduler
  import mm_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 66,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int MAT_SIZE   = MAT_SIZE_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req,
  output logic [1:0]                  gnt,
  input  logic [2*DATA_WIDTH-1:0]     op_data,
  input  logic [1:0]                  op_valid,
  output logic [1:0]                  op_ready,
  output logic [DATA_WIDTH-1:0]       res_data,
  output logic [1:0]                  res_row,
  output logic [1:0]                  res_col,
  output logic                        res_id,
  output logic                        res_valid,
  output logic                        job_done,
  output logic                        job_err,
  output logic                        busy,
  output logic                        mm_start,
  output logic [DATA_WIDTH-1:0]       mm_a_in,
  output logic [DATA_WIDTH-1:0]       mm_b_in,
  output logic [3:0]                  mm_a_addr,
  output logic [3:0]                  mm_b_addr,
  output logic                        mm_a_wen,
  output logic                        mm_b_wen,
  input  logic signed [ACC_WIDTH-1:0] mm_c_out,
  input  logic                        mm_c_valid,
  input  logic                        mm_done,
  input  logic [1:0]                  mm_row,
  input  logic [1:0]                  mm_col
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [1:0] arb_gnt;
  logic [3:0] cnt;
  logic [WW-1:0] wdog;
  logic lp, g, load, acc, last, abort, tmo;
  logic [DATA_WIDTH-1:0] word;
  logic signed [127:0] c_wide;
  assign g = gnt[1];
  assign load = state == LOAD_A || state == LOAD_B;
  assign word = op_data[g*DATA_WIDTH +: DATA_WIDTH];
  assign acc = load && req[g] && op_valid[g];
  assign last = acc && cnt == 4'(MAT_SIZE - 1);
  assign abort = load && !req[g];
  // mm_done on the final watchdog cycle still counts as a normal finish
  assign tmo = state == WAIT && !mm_done && wdog == WW'(TIMEOUT - 1);
  assign c_wide = 128'(mm_c_out) >>> FRAC_SHIFT;

  rr_arb2 u_arb (
    .req(req),
    .lp (lp),
    .en (state == IDLE),
    .gnt(arb_gnt)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req ? LOAD_A : IDLE;
      LOAD_A:  nxt = abort ? IDLE : last ? LOAD_B : LOAD_A;
      LOAD_B:  nxt = abort ? IDLE : last ? START : LOAD_B;
      START:   nxt = WAIT;
      WAIT:    nxt = mm_done || tmo ? IDLE : WAIT;
      default: nxt = IDLE;
    endcase
  end

  // ready is withdrawn as soon as the owner drops req, so an aborting cycle never accepts a word
  always_comb begin
    op_ready = load ? gnt & req : 2'b00;
    busy = state != IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      gnt <= '0;
      lp <= 1'b1;
      cnt <= '0;
      wdog <= '0;
      mm_a_in <= '0;
      mm_b_in <= '0;
      mm_a_addr <= '0;
      mm_b_addr <= '0;
      mm_a_wen <= 1'b0;
      mm_b_wen <= 1'b0;
      mm_start <= 1'b0;
      res_data <= '0;
      res_row <= '0;
      res_col <= '0;
      res_id <= 1'b0;
      res_valid <= 1'b0;
      job_done <= 1'b0;
      job_err <= 1'b0;
    end else begin
      gnt <= state == IDLE ? arb_gnt : nxt == IDLE ? 2'b00 : gnt;
      lp <= state != IDLE && nxt == IDLE ? g : lp;
      cnt <= state == IDLE || last ? 4'd0 : acc ? cnt + 4'd1 : cnt;
      mm_a_wen <= acc && state == LOAD_A;
      mm_b_wen <= acc && state == LOAD_B;
      if (acc && state == LOAD_A) begin
        mm_a_in <= word;
        mm_a_addr <= cnt;
      end
      if (acc && state == LOAD_B) begin
        mm_b_in <= word;
        mm_b_addr <= cnt;
      end
      // start is registered so it lands one cycle after the last B write
      mm_start <= state == START;
      wdog <= state == WAIT ? wdog + 1'b1 : '0;
      res_valid <= state == WAIT && mm_c_valid;
      if (state == WAIT && mm_c_valid) begin
        res_data <= DATA_WIDTH'(sat(c_wide, DATA_WIDTH));
        res_row <= mm_row;
        res_col <= mm_col;
        res_id <= g;
      end
      job_done <= state == WAIT && mm_done;
      job_err <= abort || tmo;
    end
endmodule

// File: tb/tb_mm_job_scheduler.sv
// tb_mm_job_scheduler: self-checking bench with a behavioural multiplier and reference model
module tb_mm_job_scheduler;
  typedef struct packed {logic [31:0] d; logic [1:0] row; logic [1:0] col; logic id;} res_t;
  typedef struct {logic signed [65:0] c; logic [31:0] x;} vec_t;

  logic clk = 1'b0, rst;
  logic [1:0] req, gnt, op_valid, op_ready, res_row, res_col, mm_row, mm_col;
  logic [63:0] op_data;
  logic [31:0] res_data, mm_a_in, mm_b_in;
  logic res_id, res_valid, job_done, job_err, busy, mm_start, mm_a_wen, mm_b_wen, mm_c_valid, mm_done;
  logic [3:0] mm_a_addr, mm_b_addr;
  logic signed [65:0] mm_c_out;

  int passed = 0, total = 0, cyc = 0;
  int a_n, b_n, start_n, t_start, t_err, emode, est, edly;
  logic [15:0] a_mask, b_mask;
  logic dup, overlap, lp_m;
  res_t got[$];
  vec_t tbl[9];
  logic signed [31:0] am[9], bm[9], ma[9], mb[9];

  mm_job_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .op_data(op_data), .op_valid(op_valid),
    .op_ready(op_ready), .res_data(res_data), .res_row(res_row), .res_col(res_col),
    .res_id(res_id), .res_valid(res_valid), .job_done(job_done), .job_err(job_err),
    .busy(busy), .mm_start(mm_start), .mm_a_in(mm_a_in), .mm_b_in(mm_b_in),
    .mm_a_addr(mm_a_addr), .mm_b_addr(mm_b_addr), .mm_a_wen(mm_a_wen), .mm_b_wen(mm_b_wen),
    .mm_c_out(mm_c_out), .mm_c_valid(mm_c_valid), .mm_done(mm_done), .mm_row(mm_row), .mm_col(mm_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "global timeout");
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) $display("FAIL %s: got %0h expected %0h", nm, a, x);
    else passed++;
  endtask

  function automatic logic signed [65:0] dot(input int k);
    logic signed [65:0] s = 0;
    for (int j = 0; j < 3; j++) s += 66'(ma[(k / 3) * 3 + j]) * 66'(mb[j * 3 + k % 3]);
    return s;
  endfunction

  function automatic logic signed [65:0] mprod(input int k);
    logic signed [65:0] s = 0;
    for (int j = 0; j < 3; j++) s += 66'(am[(k / 3) * 3 + j]) * 66'(bm[j * 3 + k % 3]);
    return s;
  endfunction

  function automatic logic [31:0] scale(input logic signed [65:0] v);
    logic signed [65:0] q;
    q = v / 66'sd1024;
    if (v < 0 && q * 66'sd1024 != v) q = q - 66'sd1;
    if (q > 66'sd2147483647) return 32'h7fffffff;
    if (q < -66'sd2147483648) return 32'h80000000;
    return q[31:0];
  endfunction

  function automatic logic [31:0] gd(input int k);
    return k < got.size() ? got[k].d : 32'hdeadbeef;
  endfunction

  // behavioural multiplier: captures writes, answers a start with nine results, done on the last
  always @(posedge clk) begin
    mm_c_valid <= 1'b0;
    mm_done <= 1'b0;
    if (mm_a_wen && mm_a_addr < 4'd9) ma[mm_a_addr] <= mm_a_in;
    if (mm_b_wen && mm_b_addr < 4'd9) mb[mm_b_addr] <= mm_b_in;
    if (rst) est <= 0;
    else if (mm_start) begin
      est <= 1;
      edly <= 0;
    end else if (est == 1) begin
      edly <= edly + 1;
      if (emode == 2) begin
        if (edly == 300) begin
          mm_c_valid <= 1'b1;
          mm_c_out <= 66'sd123456;
          est <= 0;
        end
      end else if (edly >= 2) begin
        mm_c_valid <= 1'b1;
        mm_row <= 2'((edly - 2) / 3);
        mm_col <= 2'((edly - 2) % 3);
        mm_c_out <= emode == 1 ? tbl[edly - 2].c : dot(edly - 2);
        if (edly == 10) begin
          mm_done <= 1'b1;
          est <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mm_a_wen) begin
      a_n++;
      if (a_mask[mm_a_addr]) dup = 1'b1;
      a_mask[mm_a_addr] = 1'b1;
    end
    if (mm_b_wen) begin
      b_n++;
      if (b_mask[mm_b_addr]) dup = 1'b1;
      b_mask[mm_b_addr] = 1'b1;
    end
    if (res_valid) got.push_back({res_data, res_row, res_col, res_id});
    if (mm_start) begin
      start_n++;
      t_start = cyc;
      if (mm_a_wen || mm_b_wen) overlap = 1'b1;
    end
    if (job_err) t_err = cyc;
  end

  task automatic rnd();
    for (int i = 0; i < 9; i++) begin
      am[i] = $signed($urandom) >>> $urandom_range(8, 31);
      bm[i] = $signed($urandom) >>> $urandom_range(8, 31);
    end
  endtask

  // mode 0: model results, 1: table results, 2: no mm_done; ab >= 0 drops req after ab words
  task automatic serve(input logic [1:0] xg, input int bub, input int mode, input int ab, input logic [1:0] drop);
    int r, idx, n;
    logic ac;
    res_t e;
    emode = mode;
    got.delete();
    a_n = 0; b_n = 0; a_mask = 0; b_mask = 0; dup = 0; start_n = 0; overlap = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 50);
    chk("grant", gnt, xg);
    if (gnt == 2'b00) return;
    r = gnt[1];
    @(posedge clk); #1;
    idx = 0; n = 0;
    while (idx < 18 && n < 400) begin
      if (idx == ab) begin
        req[r] = 1'b0;
        break;
      end
      op_data[r*32 +: 32] = idx < 9 ? am[idx] : bm[idx - 9];
      op_valid[r] = bub == 0 ? 1'b1 : bub == 1 ? ~n[0] : 1'($urandom_range(0, 1));
      @(negedge clk);
      ac = op_valid[r] & op_ready[r];
      @(posedge clk); #1;
      if (ac) idx++;
      n++;
    end
    op_valid = 2'b00;
    chk("words_loaded", idx, ab >= 0 ? ab : 18);
    n = 0;
    do begin @(negedge clk); n++; end while (!job_done && !job_err && n < 600);
    chk("job_end", {job_done, job_err}, mode == 2 || ab >= 0 ? 2'b01 : 2'b10);
    chk("gnt_release", gnt, 2'b00);
    chk("busy_idle", busy, 1'b0);
    req = req & ~drop;
    lp_m = r[0];
    @(negedge clk);
    chk("end_pulse", {job_done, job_err}, 2'b00);
    if (ab >= 0) begin
      chk("abort_no_start", start_n, 0);
      return;
    end
    chk("start_once", start_n, 1);
    chk("start_no_write", overlap, 1'b0);
    chk("a_wens", a_n, 9);
    chk("b_wens", b_n, 9);
    chk("addr_cover", {a_mask, b_mask}, {16'h01ff, 16'h01ff});
    chk("no_dup", dup, 1'b0);
    if (mode == 2) begin
      chk("timeout_cycles", t_err - t_start, 255);
      repeat (60) @(negedge clk);
      chk("late_cvalid_ignored", got.size(), 0);
      return;
    end
    chk("res_count", got.size(), 9);
    for (int k = 0; k < 9; k++) begin
      e.d = mode == 1 ? tbl[k].x : scale(mprod(k));
      e.row = 2'(k / 3);
      e.col = 2'(k % 3);
      e.id = r[0];
      chk(mode == 1 ? "table_res" : "model_res", k < got.size() ? 64'(got[k]) : 64'hbad, 64'(e));
    end
  endtask

  initial begin
    logic [1:0] rq, xg;
    int n;
    tbl[0] = '{66'sd1000000, 32'd976};
    tbl[1] = '{66'sd2000000, 32'd1953};
    tbl[2] = '{66'sd3000000, 32'd2929};
    tbl[3] = '{66'sh1000000000000000, 32'h7fffffff};
    tbl[4] = '{-66'sh1000000000000000, 32'h80000000};
    tbl[5] = '{-66'sd1, 32'hffffffff};
    tbl[6] = '{66'sh1ffffffffff, 32'h7fffffff};
    tbl[7] = '{66'sh20000000000, 32'h7fffffff};
    tbl[8] = '{-66'sh20000000001, 32'h80000000};
    rst = 1'b1; req = 2'b00; op_valid = 2'b00; op_data = '0; emode = 0; lp_m = 1'b1;
    mm_c_out = '0; mm_row = '0; mm_col = '0;
    repeat (2) @(negedge clk);
    req = 2'b11;
    @(negedge clk);
    chk("reset_ctrl", {gnt, op_ready, res_valid, job_done, job_err, busy, mm_start, mm_a_wen, mm_b_wen}, 0);
    chk("reset_data", {res_data, mm_a_in}, 0);
    chk("reset_misc", {mm_b_in, mm_a_addr, mm_b_addr, res_row, res_col, res_id}, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      am[i] = i % 4 == 0 ? 32'sd1000 : 32'sd0;
      bm[i] = 0;
    end
    bm[0] = 1000; bm[3] = 2000; bm[6] = 3000;
    serve(2'b01, 0, 0, -1, 2'b00);
    chk("identity_c00", gd(0), 976);
    chk("identity_c10", gd(3), 1953);
    chk("identity_c20", gd(6), 2929);
    rnd();
    serve(2'b10, 1, 0, -1, 2'b00);
    serve(2'b01, 0, 1, -1, 2'b11);
    rnd();
    req = 2'b01;
    serve(2'b01, 0, 2, -1, 2'b01);
    rnd();
    req = 2'b10;
    serve(2'b10, 2, 0, -1, 2'b10);
    rnd();
    req = 2'b11;
    serve(2'b01, 0, 0, 4, 2'b00);
    rnd();
    serve(2'b10, 0, 0, -1, 2'b10);
    req = 2'b01;
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 50);
    chk("rst_mid_gnt", gnt, 2'b01);
    @(posedge clk); #1;
    op_valid[0] = 1'b1;
    op_data[31:0] = 32'h1234;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {gnt, busy, op_ready, mm_a_wen, mm_b_wen, mm_start, job_err, mm_a_addr}, 0);
    chk("async_reset_data", mm_a_in, 0);
    op_valid = 2'b00;
    req = 2'b00;
    lp_m = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      rnd();
      rq = 2'($urandom_range(1, 3));
      xg = rq == 2'b11 ? (lp_m ? 2'b01 : 2'b10) : rq;
      req = rq;
      serve(xg, 2, 0, -1, 2'b11);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
